// File: rtl/vga_line_fetch.sv
// Purpose: pulls a down-scaled framebuffer one row at a time into a two-bank line buffer and emits pixel colour.
// Latency: colour and syncs follow the timing inputs by 2 cycles; mem_req rises the cycle after a trigger is sampled.
// Backpressure: mem_req holds a stable address until mem_ack; the display never stalls, late rows raise underflow.
module vga_line_fetch #(
  parameter int h_size      = 640,
  parameter int v_line      = 480,
  parameter int scale_log2  = 2,
  parameter int color_width = 8,
  parameter int addr_width  = 16,
  parameter int fb_base     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(h_size)-1:0]     h_pixel,
  input  logic [$clog2(v_line)-1:0]     v_pixel,
  input  logic                          h_sync,
  input  logic                          v_sync,
  input  logic                          active,
  output logic                          mem_req,
  output logic [addr_width-1:0]         mem_addr,
  input  logic                          mem_ack,
  input  logic [color_width-1:0]        mem_data,
  output logic [color_width-1:0]        color,
  output logic                          h_sync_out,
  output logic                          v_sync_out,
  output logic                          fetch_busy,
  output logic                          underflow
);

  localparam int fb_w  = h_size >> scale_log2;
  localparam int fb_h  = v_line >> scale_log2;
  localparam int hp_w  = $clog2(h_size);
  localparam int col_w = $clog2(fb_w);
  // One spare code so the all-ones "no row yet" marker never equals a real row.
  localparam int row_w = $clog2(fb_h + 1);

  localparam logic [addr_width-1:0] base_a = addr_width'(fb_base);
  localparam logic [addr_width-1:0] fb_w_a = addr_width'(fb_w);
  localparam logic [row_w-1:0]      last_fetchable = row_w'(fb_h - 1);
  localparam logic [col_w-1:0]      last_col       = col_w'(fb_w - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state_q, state_d;
  logic [row_w-1:0]        row_q, row_d;
  logic [col_w-1:0]        col_q, col_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [row_w-1:0]        pend_row_q, pend_row_d;
  logic [row_w-1:0]        last_row_q, last_row_d;
  logic                    underflow_q, underflow_d;

  logic                    act_d1, hs_d1, vs_d1;
  logic [color_width-1:0]  rd_data;
  logic [color_width-1:0]  line_buf [0:1][0:fb_w-1];

  logic [row_w-1:0]        disp_row;
  logic [hp_w-1:0]         disp_col_full;
  logic [col_w-1:0]        rd_col;
  logic                    vs_fall, row_start, trig, last_ack, wr_en;
  logic [row_w-1:0]        trig_row;

  // Screen position mapped onto framebuffer coordinates; blanking columns read entry 0 (masked later).
  assign disp_row      = row_w'(v_pixel >> scale_log2);
  assign disp_col_full = h_pixel >> scale_log2;
  assign rd_col        = (disp_col_full < hp_w'(fb_w)) ? col_w'(disp_col_full) : '0;

  // Trigger sources: v_sync falling edge against its registered copy, and the first active cycle of a new row.
  assign vs_fall   = vs_d1 & ~v_sync;
  assign row_start = ~vs_fall & active & (disp_row != last_row_q);
  assign trig      = vs_fall | (row_start & (disp_row < last_fetchable));
  assign trig_row  = vs_fall ? '0 : disp_row + row_w'(1);

  assign fetch_busy = (state_q == FETCH);
  assign mem_req    = fetch_busy;
  assign mem_addr   = fetch_busy ? (base_a + addr_width'(row_q) * fb_w_a + addr_width'(col_q)) : '0;
  assign wr_en      = fetch_busy & mem_ack;
  assign last_ack   = wr_en & (col_q == last_col);
  assign underflow  = underflow_q;

  // Line buffer: memory writes land in the bank of the row being fetched; display reads are registered.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[row_q[0]][col_q] <= mem_data;
    rd_data <= line_buf[disp_row[0]][rd_col];
  end

  // Display pipeline: qualifier and syncs travel alongside the buffer read so colour and syncs stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_d1     <= 1'b0;
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b1;
      color      <= '0;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      act_d1     <= active;
      hs_d1      <= h_sync;
      vs_d1      <= v_sync;
      color      <= act_d1 ? rd_data : '0;
      h_sync_out <= hs_d1;
      v_sync_out <= vs_d1;
    end
  end

  // Fetch state register; reset abandons any transfer in flight and forgets queued work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_row_q  <= '0;
      last_row_q  <= '1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_vld_q  <= pend_vld_d;
      pend_row_q  <= pend_row_d;
      last_row_q  <= last_row_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state: one word per ack; a trigger arriving while busy waits in the single pending slot.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pend_vld_d  = pend_vld_q;
    pend_row_d  = pend_row_q;
    last_row_d  = last_row_q;
    underflow_d = underflow_q;

    if (vs_fall)        last_row_d = '1;
    else if (row_start) last_row_d = disp_row;

    // A row whose final word arrives this very cycle counts as delivered in time.
    if (row_start && ((fetch_busy && (row_q == disp_row) && !last_ack) ||
                      (pend_vld_q && (pend_row_q == disp_row))))
      underflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = FETCH;
          row_d   = trig_row;
          col_d   = '0;
        end
      end
      FETCH: begin
        if (last_ack) begin
          col_d = '0;
          if (trig) begin
            // The fresh trigger would have overwritten the slot anyway, so it goes straight out.
            row_d      = trig_row;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            row_d      = pend_row_q;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (mem_ack) col_d = col_q + col_w'(1);
          if (trig) begin
            pend_vld_d = 1'b1;
            pend_row_d = trig_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Purpose: self-checking bench for vga_line_fetch against a row-job model plus literal expectations.
// Latency: bench expects colour/syncs 2 cycles after inputs and mem_req one cycle after a trigger.
// Backpressure: bench memory acks every cycle (fast) or every 8th cycle (slow) while mem_req is high.
`timescale 1ns/1ps
module tb_vga_line_fetch;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_pixel;
  logic [8:0]  v_pixel;
  logic        h_sync, v_sync, active;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  color;
  logic        h_sync_out, v_sync_out, fetch_busy, underflow;

  vga_line_fetch dut (
    .clk(clk), .reset(reset),
    .h_pixel(h_pixel), .v_pixel(v_pixel), .h_sync(h_sync), .v_sync(v_sync), .active(active),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .color(color), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .fetch_busy(fetch_busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  bit chk_en  = 0;
  bit slow    = 0;

  // monitors
  int acc_q[$];
  int acc_t[$];
  int busy_cnt = 0;
  int req_cnt  = 0;
  int t319 = -1;
  int t320 = -1;

  // model: one row job in flight, one pending, a shadow of what each bank should hold
  int m_inflight, m_words, m_pend, m_last, m_uf;
  bit m_vs_prev;
  int shadow [2][FB_W];
  bit known  [2][FB_W];
  bit s1_act, s1_hs, s1_vs, s1_known;
  int s1_data;
  int e_color;
  bit e_color_known, e_hs, e_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_inflight = -1; m_words = 0; m_pend = -1; m_last = -1; m_uf = 0; m_vs_prev = 1;
    s1_act = 0; s1_hs = 1; s1_vs = 1; s1_known = 1; s1_data = 0;
    e_color = 0; e_color_known = 1; e_hs = 1; e_vs = 1;
    foreach (known[b, i]) known[b][i] = 0;
  endtask

  // Advance the model by the cycle whose inputs are still on the pins.
  task automatic model_step();
    int  k, col, want;
    bit  vs_fall, row_start, done;
    k         = int'(v_pixel) / 4;
    col       = int'(h_pixel) / 4;
    vs_fall   = m_vs_prev && (v_sync == 1'b0);
    row_start = !vs_fall && (active == 1'b1) && (k != m_last);
    want      = -1;
    if (vs_fall) want = 0;
    else if (row_start && (k + 1 < FB_H)) want = k + 1;
    done = (m_inflight >= 0) && (mem_ack == 1'b1) && (m_words == FB_W - 1);
    if (row_start && ((m_inflight == k && !done) || m_pend == k)) m_uf = 1;

    e_color       = s1_act ? s1_data : 0;
    e_color_known = !s1_act || s1_known;
    e_hs          = s1_hs;
    e_vs          = s1_vs;
    s1_act = active; s1_hs = h_sync; s1_vs = v_sync;
    if (col < FB_W) begin
      s1_data = shadow[k % 2][col]; s1_known = known[k % 2][col];
    end else begin
      s1_data = 0; s1_known = 0;
    end

    if (m_inflight >= 0 && mem_ack == 1'b1) begin
      shadow[m_inflight % 2][m_words] = int'(mem_data);
      known[m_inflight % 2][m_words]  = 1;
      m_words++;
    end
    if (done) begin
      if (want >= 0) begin m_inflight = want; m_pend = -1; end
      else if (m_pend >= 0) begin m_inflight = m_pend; m_pend = -1; end
      else m_inflight = -1;
      m_words = 0;
    end else if (want >= 0) begin
      if (m_inflight < 0) begin m_inflight = want; m_words = 0; end
      else m_pend = want;
    end
    if (vs_fall) m_last = -1;
    else if (row_start) m_last = k;
    m_vs_prev = v_sync;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (!reset) model_reset();
    else model_step();
    mem_ack  = mem_req && (!slow || (cyc_n % 8 == 0));
    mem_data = mem_addr[7:0];
  endtask

  task automatic drive(input int h, input int v, input bit a, input bit hs, input bit vs);
    h_pixel = 10'(h); v_pixel = 9'(v); active = a; h_sync = hs; v_sync = vs;
  endtask

  task automatic blank(input int v, input int n);
    for (int i = 0; i < n; i++) begin drive(700, v, 0, 1, 1); cyc(); end
  endtask

  task automatic line(input int v);
    for (int i = 0; i < 48; i++) begin drive(i * 13, v, (v < 480), 1, 1); cyc(); end
    for (int i = 0; i < 12; i++) begin drive(640 + i * 10, v, 0, !(i >= 2 && i < 6), 1); cyc(); end
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 4; i++) begin drive(700, 490, 0, 1, 0); cyc(); end
    drive(700, 500, 0, 1, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_color"},  color, 0);
    check({tag, "_hs_out"}, h_sync_out, 1);
    check({tag, "_vs_out"}, v_sync_out, 1);
    check({tag, "_req"},    mem_req, 0);
    check({tag, "_addr"},   mem_addr, 0);
    check({tag, "_busy"},   fetch_busy, 0);
    check({tag, "_uf"},     underflow, 0);
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_req && mem_ack) begin
        acc_q.push_back(int'(mem_addr));
        acc_t.push_back(cyc_n);
        if (mem_addr == 16'd319) t319 = cyc_n;
      end
      if (mem_req && mem_addr == 16'd320 && t320 < 0) t320 = cyc_n;
      if (fetch_busy) busy_cnt++;
      if (mem_req) req_cnt++;
      check("mem_req",    mem_req,    (m_inflight >= 0));
      check("mem_addr",   mem_addr,   (m_inflight >= 0) ? m_inflight * FB_W + m_words : 0);
      check("fetch_busy", fetch_busy, (m_inflight >= 0));
      check("underflow",  underflow,  m_uf);
      check("h_sync_out", h_sync_out, e_hs);
      check("v_sync_out", v_sync_out, e_vs);
      if (e_color_known) check("color", color, e_color);
    end
  end

  initial begin
    int seq_err;
    int w;
    reset = 0; mem_ack = 0; mem_data = 0;
    drive(0, 500, 0, 1, 1);
    model_reset();
    repeat (3) cyc();
    chk_en = 1;
    check_reset_outputs("rst0");
    #2 reset = 1;
    blank(500, 20);
    check("idle_no_words", acc_q.size(), 0);

    // v_sync fall, memory acks every cycle: row 0 streams 0..159
    acc_q.delete(); acc_t.delete(); busy_cnt = 0;
    vsync_pulse();
    blank(500, 170);
    check("rowA_words", acc_q.size(), 160);
    seq_err = 0;
    foreach (acc_q[i]) if (acc_q[i] != i) seq_err++;
    check("rowA_seq_err", seq_err, 0);
    check("rowA_first", acc_q[0], 0);
    check("rowA_last", acc_q[159], 159);
    check("rowA_span", acc_t[159] - acc_t[0], 159);
    check("rowA_busy_cycles", busy_cnt, 160);

    // h_sync_out lags h_sync by exactly 2 cycles
    drive(700, 500, 0, 0, 1); cyc();
    drive(700, 500, 0, 1, 1);
    check("hs_lag_1", h_sync_out, 1);
    cyc(); check("hs_lag_2", h_sync_out, 0);
    cyc(); check("hs_lag_3", h_sync_out, 1);

    // row 0 displayed: h_pixel 9 -> index 2 -> data 2
    drive(9, 0, 1, 1, 1); cyc();
    drive(700, 0, 0, 1, 1);
    check("row0_h9_c1", color, 0);
    cyc(); check("row0_h9_color", color, 2);
    cyc(); check("blank_color", color, 0);
    for (int v = 0; v < 4; v++) line(v);

    // row 1 start fetches row 2: 320..479
    acc_q.delete(); acc_t.delete();
    for (int v = 4; v < 8; v++) line(v);
    check("row2_words", acc_q.size(), 160);
    check("row2_first", acc_q[0], 320);
    check("row2_last", acc_q[159], 479);
    check("uf_fast", underflow, 0);

    // slow memory: row 1 still in flight at v_pixel 4
    slow = 1;
    vsync_pulse();
    blank(500, 1400);
    for (int v = 0; v < 4; v++) line(v);
    check("uf_before_row1", underflow, 0);
    t319 = -1; t320 = -1;
    line(4);
    check("uf_row1_late", underflow, 1);
    for (int v = 5; v < 8; v++) line(v);
    blank(7, 1300);
    check("pend_row2_gap", t320 - t319, 1);
    slow = 0;
    vsync_pulse();
    blank(500, 400);
    line(0);
    check("uf_sticky", underflow, 1);

    // reset while waiting for an ack
    slow = 1;
    vsync_pulse();
    w = 0;
    while (!(mem_req && !mem_ack) && w < 200) begin drive(700, 500, 0, 1, 1); cyc(); w++; end
    check("wait_req_gap", (w < 200), 1);
    #2 reset = 0; model_reset(); mem_ack = 0;
    #1 check_reset_outputs("rst1");
    repeat (3) cyc();
    #2 reset = 1;
    slow = 0;
    req_cnt = 0;
    blank(500, 100);
    check("no_req_after_rst", req_cnt, 0);
    acc_q.delete(); acc_t.delete();
    vsync_pulse();
    blank(500, 170);
    check("restart_words", acc_q.size(), 160);
    check("restart_first", acc_q[0], 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Display-side pixel source that sits directly downstream of the VGA timing generator. It consumes the generator's `h_pixel`/`v_pixel`/`h_sync`/`v_sync` plus an `active` qualifier. It fetches a down-scaled framebuffer one row at a time from shared memory into a double-buffered line buffer over a req/ack bus. It emits a pixel colour with the sync signals delayed to match its pipeline.

## Interface
- `h_size`, 640, visible pixels per line (must match timing generator)
- `v_line`, 480, visible lines per frame (must match timing generator)
- `scale_log2`, 2, each framebuffer pixel covers 2^scale_log2 × 2^scale_log2 screen pixels
- `color_width`, 8, bits per colour word
- `addr_width`, 16, memory address width
- `fb_base`, 0, memory address of framebuffer pixel (0,0)
- Derived: `fb_w = h_size >> scale_log2` (160), `fb_h = v_line >> scale_log2` (120)

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `h_pixel`  in  clog2(h_size)  current column from timing generator
- `v_pixel`  in  clog2(v_line)  current line from timing generator
- `h_sync`  in  1  active-low horizontal sync
- `v_sync`  in  1  active-low vertical sync
- `active`  in  1  high while inside the visible region
- `mem_req`  out  1  read request
- `mem_addr`  out  addr_width  read address, stable while `mem_req` is high
- `mem_ack`  in  1  request accepted; `mem_data` is valid in this cycle
- `mem_data`  in  color_width  read data
- `color`  out  color_width  pixel colour, 0 outside the visible region
- `h_sync_out`  out  1  `h_sync` delayed 2 cycles
- `v_sync_out`  out  1  `v_sync` delayed 2 cycles
- `fetch_busy`  out  1  a row fetch is in progress
- `underflow`  out  1  sticky: a row was displayed before its fetch completed

## Operation
- Line buffer: 2 banks × `fb_w` words. Framebuffer row k is stored in bank k mod 2. Synchronous read; write on `mem_ack`.
- Fetch FSM has two states, IDLE and FETCH.
  - IDLE→FETCH on a fetch trigger. This loads row r, sets column c = 0 and asserts `mem_req` with `mem_addr = fb_base + r*fb_w + c`, truncated to `addr_width`.
  - In FETCH, on `mem_ack`: write `mem_data` to bank[r mod 2][c].
    - If c < fb_w−1: increment c and present the next address in the following cycle. `mem_req` stays high.
    - If c = fb_w−1: drop `mem_req` and go to IDLE, or start the pending row immediately if one is queued.
  - Only one request is outstanding at a time. `fetch_busy` is high exactly in FETCH.
- Triggers:
  - Falling edge of `v_sync` (registered compare): reset `last_row` to all-ones and trigger a fetch of row 0.
  - Row start: the first `active` cycle with `v_pixel >> scale_log2` = k ≠ `last_row`. Set `last_row` = k. If k+1 < fb_h, trigger a fetch of row k+1.
- Trigger while busy: the trigger is queued in one pending slot, and the in-flight fetch is not aborted. A second trigger while the slot is full overwrites the slot.
- Underflow:
  - `underflow` is set at a row start for row k if row k is in flight or pending.
  - Display proceeds regardless, using stale bank contents.
  - `underflow` is cleared only by reset.
- Display read: bank (k mod 2), index `h_pixel >> scale_log2`.

## Timing
- Pipeline, cycle 0 → cycle 2:
  - cycle 0: inputs sampled, line-buffer address applied.
  - cycle 1: buffer data available, and `active`/syncs delayed by one stage.
  - cycle 2: `color` registered. It equals the buffer data if `active` was high at cycle 0, else 0. `h_sync_out`/`v_sync_out` equal the cycle-0 inputs.
- Fetch rate: with `mem_ack` tied high, one word per cycle. A row takes `fb_w` cycles with `mem_req` continuously high.
- First request: `mem_req` rises in the cycle after the trigger is registered.
- Reset (asynchronous, immediate, also mid-fetch):
  - Outputs: `color` = 0, `h_sync_out` = `v_sync_out` = 1, `mem_req` = 0, `mem_addr` = 0, `fetch_busy` = 0, `underflow` = 0.
  - Internal state: FSM in IDLE, pending slot cleared, `last_row` all-ones, in-flight transfer abandoned.
  - Line-buffer contents are undefined.
  - After release, nothing is fetched until the next `v_sync` falling edge.
- Simultaneous `mem_ack` on the last word and a new trigger: the new row starts in the next cycle with c = 0, and no underflow is flagged for the completed row.

## Test plan
- Reset: drive `reset` = 0 mid-frame, then check every output at its reset value, with `mem_req` = 0 in the same cycle reset falls.
- `v_sync` falls with `mem_ack` held at 1: check `mem_addr` steps 0, 1, … 159 over 160 consecutive cycles, `fetch_busy` is high 160 cycles, then IDLE.
- Row 0 displayed with memory returning data = address[7:0]: at `active` = 1, `v_pixel` = 0, `h_pixel` = 9, check `color` = 2 two cycles later. Check `h_sync_out` lags `h_sync` by exactly 2 cycles, and `color` = 0 while `active` = 0.
- Row start at `v_pixel` = 4 (row 1): check a fetch of row 2 starts with `mem_addr` = 320 and ends at 479.
- Slow memory (`mem_ack` every 8th cycle) so row 1 is incomplete at `v_pixel` = 4: check `underflow` rises and stays 1 through the next frame. Check the pending row-2 fetch begins the cycle after row 1's last ack.
- Reset asserted while `mem_req` is high waiting for ack: check the request drops immediately, and after release `mem_req` stays 0 until the next `v_sync` falling edge, which restarts at address 0.
